// File: rtl/cmac_link_monitor.sv
// Qualifies CMAC rx alignment into a debounced link_up with event pulses,
// saturating drop/retry counters and a time-to-align capture for status.
module cmac_link_monitor #(
   parameter int unsigned UP_DEBOUNCE = 3222656,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned TIMER_W     = 32
) (
   input  logic               rx_clk,
   input  logic               rx_reset,
   input  logic               sync_rx_aligned,
   input  logic               reset_rx_datapath,
   input  logic               clear_counters,
   output logic               link_up,
   output logic               link_up_pulse,
   output logic               link_down_pulse,
   output logic [CNT_W-1:0]   link_drop_count,
   output logic [CNT_W-1:0]   retry_count,
   output logic [TIMER_W-1:0] last_align_time
);

   // Debounce counter only has to hold UP_DEBOUNCE-1.
   localparam int unsigned     DB_W    = (UP_DEBOUNCE > 1) ? $clog2(UP_DEBOUNCE) : 1;
   localparam logic [DB_W-1:0] DB_LOAD = DB_W'(UP_DEBOUNCE - 1);

   typedef enum logic [1:0] {S_DOWN, S_QUAL, S_UP} state_t;

   state_t             state_q, state_d;
   logic [DB_W-1:0]    db_q, db_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               rdp_q;
   logic               up_q, up_d;
   logic               upp_q, upp_d;
   logic               dnp_q, dnp_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic [CNT_W-1:0]   retry_q, retry_d;
   logic [TIMER_W-1:0] last_q, last_d;
   logic               abort;

   assign abort = ~sync_rx_aligned | reset_rx_datapath;

   always_comb begin
      state_d = state_q;
      db_d    = db_q;
      up_d    = up_q;
      upp_d   = 1'b0;
      dnp_d   = 1'b0;
      drop_d  = drop_q;
      retry_d = retry_q;
      last_d  = last_q;
      timer_d = timer_q;

      case (state_q)
         S_DOWN: begin
            if (!abort) begin
               state_d = S_QUAL;
               db_d    = DB_LOAD;
            end
         end
         S_QUAL: begin
            if (abort) begin
               state_d = S_DOWN;
            end else if (db_q != '0) begin
               db_d = db_q - 1'b1;
            end else begin
               state_d = S_UP;
               up_d    = 1'b1;
               upp_d   = 1'b1;
               last_d  = timer_q;
            end
         end
         S_UP: begin
            if (abort) begin
               state_d = S_DOWN;
               up_d    = 1'b0;
               dnp_d   = 1'b1;
               if (drop_q != '1) drop_d = drop_q + 1'b1;
            end
         end
         default: state_d = S_DOWN;
      endcase

      // Timer measures time since the datapath reset ended; frozen while up.
      if (reset_rx_datapath)                     timer_d = '0;
      else if (state_q != S_UP && timer_q != '1) timer_d = timer_q + 1'b1;

      if (reset_rx_datapath && !rdp_q && retry_q != '1) retry_d = retry_q + 1'b1;

      if (clear_counters) begin
         drop_d  = '0;
         retry_d = '0;
         last_d  = '0;
      end
   end

   always_ff @(posedge rx_clk or posedge rx_reset) begin
      if (rx_reset) begin
         state_q <= S_DOWN;
         db_q    <= '0;
         timer_q <= '0;
         rdp_q   <= 1'b0;
         up_q    <= 1'b0;
         upp_q   <= 1'b0;
         dnp_q   <= 1'b0;
         drop_q  <= '0;
         retry_q <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         db_q    <= db_d;
         timer_q <= timer_d;
         rdp_q   <= reset_rx_datapath;
         up_q    <= up_d;
         upp_q   <= upp_d;
         dnp_q   <= dnp_d;
         drop_q  <= drop_d;
         retry_q <= retry_d;
         last_q  <= last_d;
      end
   end

   assign link_up         = up_q;
   assign link_up_pulse   = upp_q;
   assign link_down_pulse = dnp_q;
   assign link_drop_count = drop_q;
   assign retry_count     = retry_q;
   assign last_align_time = last_q;

endmodule

// File: tb/tb_cmac_link_monitor.sv
// Bench for cmac_link_monitor: directed scenarios plus random traffic, all
// checked cycle by cycle against a run-length based reference model.
module tb_cmac_link_monitor;

   localparam int D  = 4;
   localparam int CW = 4;
   localparam int TW = 8;
   localparam int CMAX = (1 << CW) - 1;
   localparam int TMAX = (1 << TW) - 1;

   logic          rx_clk = 1'b0;
   logic          rx_reset, sync_rx_aligned, reset_rx_datapath, clear_counters;
   logic          link_up, link_up_pulse, link_down_pulse;
   logic [CW-1:0] link_drop_count, retry_count;
   logic [TW-1:0] last_align_time;

   cmac_link_monitor #(.UP_DEBOUNCE(D), .CNT_W(CW), .TIMER_W(TW)) dut (
      .rx_clk(rx_clk), .rx_reset(rx_reset), .sync_rx_aligned(sync_rx_aligned),
      .reset_rx_datapath(reset_rx_datapath), .clear_counters(clear_counters),
      .link_up(link_up), .link_up_pulse(link_up_pulse), .link_down_pulse(link_down_pulse),
      .link_drop_count(link_drop_count), .retry_count(retry_count),
      .last_align_time(last_align_time));

   always #5 rx_clk = ~rx_clk;

   wire [2*CW+TW+2:0] dut_v = {link_up, link_up_pulse, link_down_pulse,
                               link_drop_count, retry_count, last_align_time};
   logic [2*CW+TW+2:0] exp_v;

   int vecs = 0;
   int errs = 0;

   // Model: link is up once D+1 consecutive non-abort samples have been seen.
   int m_run, m_drop, m_retry, m_timer, m_last;
   bit m_up, m_upp, m_dnp, m_rdp_prev;

   task automatic model_reset();
      m_run = 0; m_drop = 0; m_retry = 0; m_timer = 0; m_last = 0;
      m_up = 0; m_upp = 0; m_dnp = 0; m_rdp_prev = 0;
      exp_v = '0;
   endtask

   task automatic tick();
      bit ab, n_up;
      int n_run, n_drop, n_retry, n_timer, n_last;
      logic [CW-1:0] a, b;
      logic [TW-1:0] c;
      ab      = !sync_rx_aligned || reset_rx_datapath;
      n_run   = ab ? 0 : ((m_run < D + 1) ? m_run + 1 : D + 1);
      n_up    = (n_run >= D + 1);
      n_drop  = m_drop;
      n_retry = m_retry;
      n_last  = m_last;
      if (m_up && !n_up && n_drop < CMAX) n_drop++;
      if (reset_rx_datapath && !m_rdp_prev && n_retry < CMAX) n_retry++;
      if (n_up && !m_up) n_last = m_timer;
      if (clear_counters) begin n_drop = 0; n_retry = 0; n_last = 0; end
      if (reset_rx_datapath) n_timer = 0;
      else if (!m_up)        n_timer = (m_timer < TMAX) ? m_timer + 1 : TMAX;
      else                   n_timer = m_timer;
      @(posedge rx_clk); #1;
      m_upp = n_up && !m_up;
      m_dnp = m_up && !n_up;
      m_up = n_up; m_run = n_run; m_drop = n_drop; m_retry = n_retry;
      m_last = n_last; m_timer = n_timer; m_rdp_prev = reset_rx_datapath;
      a = m_drop[CW-1:0]; b = m_retry[CW-1:0]; c = m_last[TW-1:0];
      exp_v = {m_up, m_upp, m_dnp, a, b, c};
   endtask

   task automatic cyc(input bit al, input bit rdp, input bit clr);
      sync_rx_aligned   = al;
      reset_rx_datapath = rdp;
      clear_counters    = clr;
      tick();
   endtask

   task automatic test_reset();
      rx_reset = 1; sync_rx_aligned = 0; reset_rx_datapath = 0; clear_counters = 0;
      repeat (2) @(posedge rx_clk);
      #1;
      if (dut_v !== '0) begin errs++; $display("FAIL reset: got %h expected 0", dut_v); end
      vecs++;
      rx_reset = 0;
      model_reset();
   endtask

   task automatic test_first_align();
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, 0);
         if (dut_v !== exp_v) begin errs++; $display("FAIL first_align rdp %0d: got %h expected %h", i, dut_v, exp_v); end
         vecs++;
      end
      for (int i = 0; i < 20; i++) begin
         cyc(0, 0, 0);
         if (dut_v !== exp_v) begin errs++; $display("FAIL first_align idle %0d: got %h expected %h", i, dut_v, exp_v); end
         vecs++;
      end
      for (int k = 1; k <= 6; k++) begin
         cyc(1, 0, 0);
         if (dut_v !== exp_v) begin errs++; $display("FAIL first_align qual %0d: got %h expected %h", k, dut_v, exp_v); end
         vecs++;
         if ({link_up, link_up_pulse} !== ((k < 5) ? 2'b00 : (k == 5) ? 2'b11 : 2'b10)) begin
            errs++; $display("FAIL first_align latency k=%0d: got up=%b pulse=%b", k, link_up, link_up_pulse);
         end
         vecs++;
      end
      if (retry_count !== 4'd1) begin errs++; $display("FAIL first_align retry: got %0d expected 1", retry_count); end
      vecs++;
      if (last_align_time !== 8'd24) begin errs++; $display("FAIL first_align time: got %0d expected 24", last_align_time); end
      vecs++;
   endtask

   task automatic test_drop();
      cyc(0, 0, 0);
      if (dut_v !== exp_v) begin errs++; $display("FAIL drop: got %h expected %h", dut_v, exp_v); end
      vecs++;
      if ({link_up, link_down_pulse, link_drop_count} !== {2'b01, 4'd1}) begin
         errs++; $display("FAIL drop event: got up=%b dn=%b cnt=%0d expected 0 1 1", link_up, link_down_pulse, link_drop_count);
      end
      vecs++;
      for (int k = 1; k <= 6; k++) begin
         cyc(1, 0, 0);
         if (dut_v !== exp_v) begin errs++; $display("FAIL drop requal %0d: got %h expected %h", k, dut_v, exp_v); end
         vecs++;
      end
      if (link_up !== 1'b1) begin errs++; $display("FAIL drop requal up: got %b expected 1", link_up); end
      vecs++;
   endtask

   task automatic test_glitch();
      bit pat [12] = '{0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
      for (int i = 0; i < 12; i++) begin
         cyc(pat[i], 0, 0);
         if (dut_v !== exp_v) begin errs++; $display("FAIL glitch %0d: got %h expected %h", i, dut_v, exp_v); end
         vecs++;
         if (i >= 2 && i < 10 && (link_up !== 1'b0 || link_up_pulse !== 1'b0)) begin
            errs++; $display("FAIL glitch early up %0d: got up=%b pulse=%b expected 0 0", i, link_up, link_up_pulse);
         end
         vecs++;
      end
      if (link_up !== 1'b1) begin errs++; $display("FAIL glitch final: got %b expected 1", link_up); end
      vecs++;
   endtask

   task automatic test_rdp_while_up();
      logic [CW-1:0] d0, r0;
      d0 = link_drop_count; r0 = retry_count;
      cyc(1, 1, 0);
      if (dut_v !== exp_v) begin errs++; $display("FAIL rdp_up: got %h expected %h", dut_v, exp_v); end
      vecs++;
      if ({link_up, link_drop_count, retry_count} !== {1'b0, d0 + 4'd1, r0 + 4'd1}) begin
         errs++; $display("FAIL rdp_up counts: got up=%b drop=%0d retry=%0d", link_up, link_drop_count, retry_count);
      end
      vecs++;
      for (int k = 1; k <= 5; k++) begin
         cyc(1, 0, 0);
         if (dut_v !== exp_v) begin errs++; $display("FAIL rdp_up requal %0d: got %h expected %h", k, dut_v, exp_v); end
         vecs++;
      end
      if (last_align_time !== 8'd4) begin errs++; $display("FAIL rdp_up time: got %0d expected 4", last_align_time); end
      vecs++;
   endtask

   task automatic test_saturation();
      for (int n = 0; n < 17; n++) begin
         for (int k = 0; k < 6; k++) begin
            cyc(k < 5, 0, 0);
            if (dut_v !== exp_v) begin errs++; $display("FAIL sat n=%0d k=%0d: got %h expected %h", n, k, dut_v, exp_v); end
            vecs++;
         end
      end
      if (link_drop_count !== 4'd15) begin errs++; $display("FAIL sat hold: got %0d expected 15", link_drop_count); end
      vecs++;
      for (int k = 0; k < 5; k++) cyc(1, 0, 0);
      cyc(0, 0, 1);
      if (dut_v !== exp_v) begin errs++; $display("FAIL clear: got %h expected %h", dut_v, exp_v); end
      vecs++;
      if ({link_drop_count, retry_count, last_align_time, link_down_pulse} !== {16'h0, 1'b1}) begin
         errs++; $display("FAIL clear win: got drop=%0d retry=%0d time=%0d dn=%b", link_drop_count, retry_count, last_align_time, link_down_pulse);
      end
      vecs++;
   endtask

   task automatic test_timer_sat();
      for (int i = 0; i < 300; i++) cyc(0, 0, 0);
      for (int k = 0; k < 5; k++) cyc(1, 0, 0);
      if (dut_v !== exp_v) begin errs++; $display("FAIL timer_sat: got %h expected %h", dut_v, exp_v); end
      vecs++;
      if (last_align_time !== 8'd255) begin errs++; $display("FAIL timer_sat value: got %0d expected 255", last_align_time); end
      vecs++;
   endtask

   task automatic test_reset_mid();
      cyc(0, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
      #2 rx_reset = 1;
      #1;
      if (dut_v !== '0) begin errs++; $display("FAIL reset_qual: got %h expected 0", dut_v); end
      vecs++;
      @(posedge rx_clk); #1 rx_reset = 0;
      model_reset();
      for (int k = 0; k < 5; k++) cyc(1, 0, 0);
      if (dut_v !== exp_v) begin errs++; $display("FAIL reset_requal: got %h expected %h", dut_v, exp_v); end
      vecs++;
      #2 rx_reset = 1;
      #1;
      if (dut_v !== '0) begin errs++; $display("FAIL reset_up: got %h expected 0", dut_v); end
      vecs++;
      for (int k = 0; k < 3; k++) begin
         @(posedge rx_clk); #1;
         if (dut_v !== '0) begin errs++; $display("FAIL reset_hold %0d: got %h expected 0", k, dut_v); end
         vecs++;
      end
      rx_reset = 0;
      model_reset();
      cyc(1, 0, 0);
      if (dut_v !== exp_v) begin errs++; $display("FAIL reset_release: got %h expected %h", dut_v, exp_v); end
      vecs++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(99) < 88, $urandom_range(99) < 3, $urandom_range(99) < 2);
         if (dut_v !== exp_v) begin errs++; $display("FAIL random %0d: got %h expected %h", i, dut_v, exp_v); end
         vecs++;
         if (link_up_pulse && link_down_pulse) begin errs++; $display("FAIL random both pulses %0d: got 1 1", i); end
         vecs++;
      end
   endtask

   initial begin
      test_reset();
      test_first_align();
      test_drop();
      test_glitch();
      test_rdp_while_up();
      test_saturation();
      test_timer_sat();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
